// File: rtl/siso_shift_ctrl.sv
// Serial-in/serial-out chain controller: shifts a parallel word out MSB first,
// flushes the external chain, and reassembles the returned bits for comparison.
module siso_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_en,
  input  logic             ser_ret,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             match,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [WIDTH-1:0] tx_reg, rx_reg;
  logic            accept;
  logic            capture;
  logic [IW-1:0]   bit_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept)  tx_reg <= in_data;
      if (capture) rx_reg <= {rx_reg[WIDTH-2:0], ser_ret};
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    in_ready  = 1'b0;
    accept    = 1'b0;
    ser_en    = 1'b0;
    ser_out   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    match     = 1'b0;
    bit_idx   = IW'(WIDTH - 1) - count[IW-1:0];
    case (state)
      IDLE: begin
        in_ready = ~reset;
        accept   = in_valid & ~reset;
        if (accept) begin
          state_nxt = SHIFT;
          count_nxt = '0;
        end
      end
      SHIFT: begin
        ser_en    = 1'b1;
        ser_out   = tx_reg[bit_idx];
        count_nxt = count + 1'b1;
        if (count == SHIFT_LAST) state_nxt = FLUSH;
      end
      FLUSH: begin
        ser_en    = 1'b1;
        count_nxt = count + 1'b1;
        if (count == FLUSH_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = rx_reg;
        match     = (rx_reg == tx_reg);
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The chain delays by DEPTH enabled cycles, so returned bits start at count DEPTH.
  assign capture = ser_en & (count >= CAP_FIRST);
  assign busy    = (state != IDLE);

endmodule

// File: doc/siso_shift_ctrl.md
SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 4: number of register stages in the external SISO chain; SHALL be >= 1.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  parallel word offered.
REQ-006 Port in_ready  output  1  controller accepts a word this cycle.
REQ-007 Port in_data  input  WIDTH  word to transmit.
REQ-008 Port ser_out  output  1  bit driven into the chain's serial_in.
REQ-009 Port ser_en  output  1  shift enable for the chain.
REQ-010 Port ser_ret  input  1  chain's serial_out, returned to the controller.
REQ-011 Port out_valid  output  1  received word available.
REQ-012 Port out_ready  input  1  consumer takes the received word.
REQ-013 Port out_data  output  WIDTH  word reassembled from ser_ret.
REQ-014 Port match  output  1  out_data equals the transmitted word; valid only while out_valid=1.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, SHIFT, FLUSH, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a word is accepted on the edge where in_valid=1 and in_ready=1.
REQ-018 On acceptance, the block SHALL latch in_data into tx_reg, clear the bit counter, and enter SHIFT.
REQ-019 in_valid SHALL be ignored in SHIFT, FLUSH and DONE.
REQ-020 SHIFT SHALL last exactly WIDTH cycles with ser_en=1, driving ser_out = tx_reg bits MSB first, one bit per cycle.
REQ-021 FLUSH SHALL last exactly DEPTH cycles with ser_en=1 and ser_out=0.
REQ-022 ser_en SHALL be 0 and ser_out SHALL be 0 in IDLE and DONE.
REQ-023 A single counter SHALL span SHIFT and FLUSH, running 0..WIDTH+DEPTH-1, with width clog2(WIDTH+DEPTH+1).
- SHIFT to FLUSH when count = WIDTH-1.
- FLUSH to DONE when count = WIDTH+DEPTH-1.
REQ-024 On every ser_en=1 cycle with count >= DEPTH, ser_ret SHALL be shifted into rx_reg LSB-in (rx_reg <= {rx_reg[WIDTH-2:0], ser_ret}); after FLUSH, rx_reg holds the WIDTH returned bits MSB-aligned.
REQ-025 In DONE: out_valid=1, out_data=rx_reg, and match=(rx_reg==tx_reg); all three SHALL hold stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on that edge; a new word SHALL NOT be accepted in that same cycle (earliest acceptance is the next cycle).
REQ-027 Latency from the acceptance edge to out_valid=1 SHALL be WIDTH+DEPTH+1 cycles.
REQ-028 out_data and match SHALL read 0 whenever out_valid=0.

Reset
REQ-029 Asserting reset in any state, including mid-SHIFT or mid-FLUSH, SHALL immediately force the following, with no partial word delivered:
- state=IDLE, counter=0, tx_reg=0, rx_reg=0;
- in_ready=0 while reset is asserted;
- ser_out=0, ser_en=0, out_valid=0, out_data=0, match=0, busy=0.
REQ-030 After reset deasserts, in_ready SHALL be 1 from the first clock edge onward.

Verification
REQ-031 The bench SHALL model the chain as a DEPTH-stage shift register gated by ser_en, with WIDTH=8 and DEPTH=4, and SHALL cover:
- Accept 0xA5 -> ser_out 1,0,1,0,0,1,0,1 then 0,0,0,0; out_valid=1 on cycle 13 after acceptance; out_data=0xA5, match=1.
- Chain output forced to 0, send 0xFF -> out_data=0x00, match=0.
- Send 0x3C with out_ready held 0 for 5 cycles after out_valid -> out_valid/out_data/match stable; IDLE one cycle after out_ready=1.
- in_valid held 1 with 0x81 then 0x7E back-to-back -> second word accepted exactly one cycle after the first DONE handshake; both round-trip with match=1.
- Reset asserted on count=3 of SHIFT -> all outputs 0 at once; a following 0x5A round-trips correctly.
- in_valid pulsed during FLUSH -> ignored, no state change.
